// File: rtl/des_round_ctrl.sv
// DES round sequencer: drives the load, round, key-rotation and output-capture
// controls of an iterative (one round per clock) DES datapath. It holds no
// datapath state of its own; it only tracks state, round count and mode.
module des_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       decrypt,
  output logic       init_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROUND  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd15;

  // Encrypt-direction rotation amounts, round 0 in the two LSBs.
  // Rounds 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28, a full turn of C/D).
  localparam logic [31:0] ENC_SHIFTS = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       mode_reg, mode_next;

  logic [1:0] enc_tbl [16];
  logic [1:0] dec_tbl [16];

  // Decrypt walks the key schedule backwards: round 0 uses the unrotated
  // PC1 key (K16), and round r undoes the left shift of encrypt round 16-r.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sched
      assign enc_tbl[gi] = ENC_SHIFTS[2*gi +: 2];
      if (gi == 0) begin : g_first
        assign dec_tbl[gi] = 2'd0;
      end else begin : g_rest
        assign dec_tbl[gi] = ENC_SHIFTS[2*(16-gi) +: 2];
      end
    end
  endgenerate

  // State, round counter and latched mode; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  // Next-state logic and control outputs; outputs depend only on registered state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    start_ready = 1'b0;
    init_load   = 1'b0;
    round_en    = 1'b0;
    round_idx   = 4'd0;
    key_shift   = 2'd0;
    key_dir     = mode_reg;
    fp_load     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          mode_next  = decrypt;
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy       = 1'b1;
        init_load  = 1'b1;
        cnt_next   = 4'd0;
        state_next = ST_ROUND;
      end

      ST_ROUND: begin
        busy      = 1'b1;
        round_en  = 1'b1;
        round_idx = cnt_reg;
        key_shift = mode_reg ? dec_tbl[cnt_reg] : enc_tbl[cnt_reg];
        if (cnt_reg == LAST_ROUND) begin
          // Round 16 results are on the datapath combinationally this cycle,
          // so the final permutation is captured alongside the last round.
          fp_load    = 1'b1;
          cnt_next   = 4'd0;
          state_next = ST_OUTPUT;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      ST_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule
